pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/redirect sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: PC select encodings, sequencer states,
// opcode constants and the packed control word driven by the hazard sequencer.
package pipe_pkg;

    localparam logic [2:0] PC_SEQ    = 3'b000;
    localparam logic [2:0] PC_JUMP   = 3'b001;
    localparam logic [2:0] PC_JR     = 3'b010;
    localparam logic [2:0] PC_BRANCH = 3'b100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] pcSrc;
        logic       pcWrite;
        logic       ifidWrite;
        logic       ifFlush;
        logic       idexWrite;
        logic       idexFlush;
        logic       exmemWrite;
        logic       exmemFlush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{PC_SEQ,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctrl_t CTRL_STALL  = '{PC_SEQ,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{PC_SEQ,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{PC_BRANCH, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Combinational register-compare for load-use hazards and for jr reading a
// register that the instruction in EX has not yet produced.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             usesRt_ID,
    input  logic             memRead_EX,
    input  logic             regWrite_EX,
    input  logic [REG_W-1:0] regSel_EX,
    output logic             loadUse,
    output logic             jrHazard
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (regSel_EX == rs_ID);
    assign rtMatch = usesRt_ID && (regSel_EX == rt_ID);

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign loadUse  = memRead_EX && (|regSel_EX) && (rsMatch || rtMatch);
    assign jrHazard = regWrite_EX && rsMatch && (|rs_ID);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int OP_W        = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OP_W-1:0]  opCode_ID,
    input  logic             jr_ID,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             usesRt_ID,
    input  logic             memRead_EX,
    input  logic             regWrite_EX,
    input  logic [REG_W-1:0] regSel_EX,
    input  logic             branchCtrl,
    input  logic             memAccess_MEM,
    input  logic             memReady,
    output logic [2:0]       PCSrc,
    output logic             pcWrite,
    output logic             IFIDWrite,
    output logic             IFFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             EXMEMWrite,
    output logic             EXMEMFlush,
    output logic             memError
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      stallCount,
    output logic [15:0]      flushCount
`endif
);

    state_e     state, nextState;
    logic [3:0] timer;
    logic       pendingBr, nextPending;
    ctrl_t      ctrl;
    logic       loadUse, jrHazard;
    logic       isJr, isJump, timeout;

    hazard_detect #(.REG_W(REG_W)) uDetect (
        .rs_ID       (rs_ID),
        .rt_ID       (rt_ID),
        .usesRt_ID   (usesRt_ID),
        .memRead_EX  (memRead_EX),
        .regWrite_EX (regWrite_EX),
        .regSel_EX   (regSel_EX),
        .loadUse     (loadUse),
        .jrHazard    (jrHazard)
    );

    assign isJr    = jr_ID && (opCode_ID == OP_W'(OP_RTYPE));
    assign isJump  = (opCode_ID == OP_W'(OP_J)) || (opCode_ID == OP_W'(OP_JAL));
    assign timeout = (timer == 4'(MEM_TIMEOUT - 1));

    always_comb begin
        ctrl        = CTRL_IDLE;
        nextState   = state;
        nextPending = pendingBr;
        memError    = 1'b0;
        case (state)
            RUN: begin
                if (memAccess_MEM && !memReady) begin
                    ctrl        = CTRL_FREEZE;
                    nextState   = MEM_WAIT;
                    nextPending = branchCtrl;
                end else if (branchCtrl) begin
                    ctrl = CTRL_BRANCH;
                end else if (isJr) begin
                    if (jrHazard) begin
                        ctrl = CTRL_STALL;
                    end else begin
                        ctrl.pcSrc   = PC_JR;
                        ctrl.ifFlush = 1'b1;
                    end
                end else if (loadUse) begin
                    // Also wins over a jump in ID; the jump is re-decoded next cycle.
                    ctrl = CTRL_STALL;
                end else if (isJump) begin
                    ctrl.pcSrc   = PC_JUMP;
                    ctrl.ifFlush = 1'b1;
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                // Any branch seen while frozen is remembered so it cannot be lost.
                nextPending = pendingBr || branchCtrl;
                if (memReady || timeout) begin
                    nextState = nextPending ? REDIRECT : RUN;
                    memError  = !memReady;
                end
            end
            REDIRECT: begin
                ctrl        = CTRL_BRANCH;
                nextPending = 1'b0;
                nextState   = RUN;
            end
            default: begin
                nextState   = RUN;
                nextPending = 1'b0;
            end
        endcase
    end

    assign PCSrc      = ctrl.pcSrc;
    assign pcWrite    = ctrl.pcWrite;
    assign IFIDWrite  = ctrl.ifidWrite;
    assign IFFlush    = ctrl.ifFlush;
    assign IDEXWrite  = ctrl.idexWrite;
    assign IDEXFlush  = ctrl.idexFlush;
    assign EXMEMWrite = ctrl.exmemWrite;
    assign EXMEMFlush = ctrl.exmemFlush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            timer     <= 4'd0;
            pendingBr <= 1'b0;
        end else begin
            state     <= nextState;
            pendingBr <= nextPending;
            timer     <= (state == MEM_WAIT) ? timer + 4'd1 : 4'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount <= 16'd0;
            flushCount <= 16'd0;
        end else begin
            if (!pcWrite && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
            if (IFFlush && flushCount != 16'hFFFF)  flushCount <= flushCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN-state priority,
// hand sequences for memory waits, deferred branch, timeout and reset mid-wait.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opCode_ID;
    logic       jr_ID;
    logic [4:0] rs_ID, rt_ID, regSel_EX;
    logic       usesRt_ID, memRead_EX, regWrite_EX, branchCtrl, memAccess_MEM, memReady;
    logic [2:0] PCSrc;
    logic       pcWrite, IFIDWrite, IFFlush, IDEXWrite, IDEXFlush, EXMEMWrite, EXMEMFlush, memError;
`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount, flushCount;
`endif

    pipeline_hazard_ctrl dut (
        .clock(clock), .reset(reset), .opCode_ID(opCode_ID), .jr_ID(jr_ID),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .usesRt_ID(usesRt_ID), .memRead_EX(memRead_EX),
        .regWrite_EX(regWrite_EX), .regSel_EX(regSel_EX), .branchCtrl(branchCtrl),
        .memAccess_MEM(memAccess_MEM), .memReady(memReady), .PCSrc(PCSrc),
        .pcWrite(pcWrite), .IFIDWrite(IFIDWrite), .IFFlush(IFFlush), .IDEXWrite(IDEXWrite),
        .IDEXFlush(IDEXFlush), .EXMEMWrite(EXMEMWrite), .EXMEMFlush(EXMEMFlush),
        .memError(memError)
`ifdef HAZARD_STATS_EN
        , .stallCount(stallCount), .flushCount(flushCount)
`endif
    );

    always #5 clock = ~clock;

    // {PCSrc, pcWrite, IFIDWrite, IFFlush, IDEXWrite, IDEXFlush, EXMEMWrite, EXMEMFlush}
    logic [9:0] outWord;
    assign outWord = {PCSrc, pcWrite, IFIDWrite, IFFlush, IDEXWrite, IDEXFlush, EXMEMWrite, EXMEMFlush};

    localparam logic [9:0] W_IDLE   = 10'b000_1_1_0_1_0_1_0;
    localparam logic [9:0] W_STALL  = 10'b000_0_0_0_1_1_1_0;
    localparam logic [9:0] W_FREEZE = 10'b000_0_0_0_0_0_0_0;
    localparam logic [9:0] W_BRANCH = 10'b100_1_1_1_1_1_1_1;
    localparam logic [9:0] W_JR     = 10'b010_1_1_1_1_0_1_0;
    localparam logic [9:0] W_JUMP   = 10'b001_1_1_1_1_0_1_0;

    typedef struct {
        string      name;
        logic [5:0] opc;
        logic       jr;
        logic [4:0] rs, rt;
        logic       usesRt, memRead, regWrite;
        logic [4:0] regSel;
        logic       br, mem, rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[17];
    int   passCnt = 0;
    int   totalCnt = 0;

    function automatic vec_t mk(string n, logic [5:0] opc, logic jr, logic [4:0] rs, logic [4:0] rt,
                                logic usesRt, logic memRead, logic regWrite, logic [4:0] regSel,
                                logic br, logic mem, logic rdy, logic [9:0] exp);
        vec_t v;
        v.name = n; v.opc = opc; v.jr = jr; v.rs = rs; v.rt = rt; v.usesRt = usesRt;
        v.memRead = memRead; v.regWrite = regWrite; v.regSel = regSel; v.br = br;
        v.mem = mem; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passCnt++;
    endtask

    task automatic idle();
        opCode_ID = 6'h08; jr_ID = 1'b0; rs_ID = 5'd1; rt_ID = 5'd2; usesRt_ID = 1'b0;
        memRead_EX = 1'b0; regWrite_EX = 1'b0; regSel_EX = 5'd0; branchCtrl = 1'b0;
        memAccess_MEM = 1'b0; memReady = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        opCode_ID = v.opc; jr_ID = v.jr; rs_ID = v.rs; rt_ID = v.rt; usesRt_ID = v.usesRt;
        memRead_EX = v.memRead; regWrite_EX = v.regWrite; regSel_EX = v.regSel;
        branchCtrl = v.br; memAccess_MEM = v.mem; memReady = v.rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int errIdx, pulses, freezeBad;

        //              name           opc   jr rs  rt usesRt mRd rWr sel br mem rdy exp
        vecs[0]  = mk("idle",          6'h08, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0, W_IDLE);
        vecs[1]  = mk("loaduse_rs",    6'h00, 0, 5'd5, 5'd6, 1, 1, 1, 5'd5, 0, 0, 0, W_STALL);
        vecs[2]  = mk("loaduse_rt",    6'h00, 0, 5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, W_STALL);
        vecs[3]  = mk("rt_unused",     6'h00, 0, 5'd3, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, W_IDLE);
        vecs[4]  = mk("loaduse_r0",    6'h00, 0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, W_IDLE);
        vecs[5]  = mk("alu_fwd",       6'h00, 0, 5'd5, 5'd6, 1, 0, 1, 5'd5, 0, 0, 0, W_IDLE);
        vecs[6]  = mk("branch",        6'h08, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, 0, W_BRANCH);
        vecs[7]  = mk("branch_lu",     6'h00, 0, 5'd5, 5'd6, 1, 1, 1, 5'd5, 1, 0, 0, W_BRANCH);
        vecs[8]  = mk("jr_clean",      6'h00, 1, 5'd9, 5'd0, 0, 0, 1, 5'd4, 0, 0, 0, W_JR);
        vecs[9]  = mk("jr_hazard",     6'h00, 1, 5'd9, 5'd0, 0, 0, 1, 5'd9, 0, 0, 0, W_STALL);
        vecs[10] = mk("jr_r0",         6'h00, 1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, W_JR);
        vecs[11] = mk("jump",          6'h02, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0, W_JUMP);
        vecs[12] = mk("jal",           6'h03, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0, W_JUMP);
        vecs[13] = mk("jump_lu",       6'h02, 0, 5'd4, 5'd2, 0, 1, 1, 5'd4, 0, 0, 0, W_STALL);
        vecs[14] = mk("branch_jump",   6'h02, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 0, 0, W_BRANCH);
        vecs[15] = mk("mem_ready_now", 6'h08, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 1, 1, W_IDLE);
        vecs[16] = mk("mem_rdy_br",    6'h08, 0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 1, W_BRANCH);

        reset = 1'b0;
        idle();
        @(negedge clock); @(negedge clock);
        chk("reset_outs", 32'(outWord), 32'(W_IDLE));
        chk("reset_memError", 32'(memError), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("reset_stallCount", 32'(stallCount), 32'd0);
        chk("reset_flushCount", 32'(flushCount), 32'd0);
`endif
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            apply(vecs[i]);
            #1 chk(vecs[i].name, 32'(outWord), 32'(vecs[i].exp));
        end

        // Load-use stalls exactly one cycle; the bubble then sits in EX.
        @(negedge clock); idle();
        opCode_ID = 6'h00; rs_ID = 5'd5; memRead_EX = 1'b1; regWrite_EX = 1'b1; regSel_EX = 5'd5;
        #1 chk("lu_seq_stall", 32'(outWord), 32'(W_STALL));
        @(negedge clock); memRead_EX = 1'b0; regWrite_EX = 1'b0; regSel_EX = 5'd0;
        #1 chk("lu_seq_resume", 32'(outWord), 32'(W_IDLE));

        // Memory wait: ready low for three cycles, then high.
        @(negedge clock); idle(); memAccess_MEM = 1'b1;
        #1 chk("mw_c0", 32'(outWord), 32'(W_FREEZE));
        @(negedge clock); #1 chk("mw_c1", 32'(outWord), 32'(W_FREEZE));
        @(negedge clock); #1 chk("mw_c2", 32'(outWord), 32'(W_FREEZE));
        @(negedge clock); memReady = 1'b1;
        #1 chk("mw_ready_outs", 32'(outWord), 32'(W_FREEZE));
        chk("mw_ready_noerr", 32'(memError), 32'd0);
        @(negedge clock); idle();
        #1 chk("mw_back_run", 32'(outWord), 32'(W_IDLE));

        // Branch arriving as the wait starts is replayed once after the wait.
        @(negedge clock); idle(); memAccess_MEM = 1'b1; branchCtrl = 1'b1;
        #1 chk("db_entry", 32'(outWord), 32'(W_FREEZE));
        @(negedge clock); branchCtrl = 1'b0;
        #1 chk("db_wait", 32'(outWord), 32'(W_FREEZE));
        @(negedge clock); memReady = 1'b1;
        @(negedge clock); idle();
        #1 chk("db_redirect", 32'(outWord), 32'(W_BRANCH));
        @(negedge clock);
        #1 chk("db_after", 32'(outWord), 32'(W_IDLE));

        // Memory never answers: error pulse on the 15th wait cycle, then resume.
        @(negedge clock); idle(); memAccess_MEM = 1'b1;
        errIdx = -1; pulses = 0; freezeBad = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (memError) begin
                pulses++;
                if (errIdx < 0) errIdx = c;
            end
            if (outWord !== W_FREEZE) freezeBad++;
            @(negedge clock);
        end
        idle();
        #1 chk("to_err_cycle", 32'(errIdx), 32'd15);
        chk("to_err_pulses", 32'(pulses), 32'd1);
        chk("to_frozen", 32'(freezeBad), 32'd0);
        chk("to_resume", 32'(outWord), 32'(W_IDLE));
        chk("to_err_clear", 32'(memError), 32'd0);

        // Reset during a wait with a branch pending: no redirect afterwards.
        @(negedge clock); idle(); memAccess_MEM = 1'b1; branchCtrl = 1'b1;
        @(negedge clock); branchCtrl = 1'b0;
        @(negedge clock); reset = 1'b0; idle();
        #1 chk("rst_wait_outs", 32'(outWord), 32'(W_IDLE));
`ifdef HAZARD_STATS_EN
        chk("rst_wait_stallCount", 32'(stallCount), 32'd0);
`endif
        @(negedge clock); reset = 1'b1;
        #1 chk("rst_no_redirect", 32'(outWord), 32'(W_IDLE));
        @(negedge clock);
        #1 chk("rst_run", 32'(outWord), 32'(W_IDLE));

`ifdef HAZARD_STATS_EN
        @(negedge clock); idle();
        opCode_ID = 6'h00; rs_ID = 5'd5; memRead_EX = 1'b1; regWrite_EX = 1'b1; regSel_EX = 5'd5;
        @(negedge clock); idle(); branchCtrl = 1'b1;
        @(negedge clock); idle();
        #1 chk("stats_stall", 32'(stallCount), 32'd1);
        chk("stats_flush", 32'(flushCount), 32'd1);
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
